threshold_cfg_seq: RTL and testbench



---
 rtl/threshold_cfg_seq.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_threshold_cfg_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_cfg_seq.sv
// AXI4-Lite master that writes a fixed register bank from a parallel
// configuration word, with optional readback compare and timeout.
module threshold_cfg_seq #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int C_NUM_REGS = 4,
  parameter int C_TIMEOUT = 255
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic start,
  input  logic verify,
  input  logic [C_M_AXI_DATA_WIDTH*C_NUM_REGS-1:0] cfg_data,
  output logic busy,
  output logic done,
  output logic error,
  output logic [1:0] err_code,
  output logic [1:0] err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0] M_AXI_AWPROT,
  output logic M_AXI_AWVALID,
  input  logic M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic M_AXI_WVALID,
  input  logic M_AXI_WREADY,
  input  logic [1:0] M_AXI_BRESP,
  input  logic M_AXI_BVALID,
  output logic M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0] M_AXI_ARPROT,
  output logic M_AXI_ARVALID,
  input  logic M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0] M_AXI_RRESP,
  input  logic M_AXI_RVALID,
  output logic M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR,
    S_RD_DATA, S_CHECK, S_NEXT, S_FINISH
  } state_t;

  state_t r_state;
  logic [1:0] r_idx;
  logic [DW*C_NUM_REGS-1:0] r_cfg;
  logic r_verify;
  logic [CW-1:0] r_cnt;
  logic r_aw_done;
  logic r_w_done;
  logic [DW-1:0] r_rdata;
  logic r_busy;
  logic r_done;
  logic r_error;
  logic [1:0] r_err_code;
  logic [1:0] r_err_index;
  logic [AW-1:0] r_awaddr;
  logic [AW-1:0] r_araddr;
  logic [DW-1:0] r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic r_awvalid;
  logic r_wvalid;
  logic r_bready;
  logic r_arvalid;
  logic r_rready;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_wr_fin;
  logic w_tmo;
  logic w_last;
  logic [1:0] w_idx_nxt;
  logic w_fail;
  logic w_end;
  logic [1:0] w_fcode;

  function automatic logic [AW-1:0] f_addr(input logic [1:0] i);
    return C_BASE_ADDR + AW'({i, 2'b00});
  endfunction

  assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid & M_AXI_WREADY;
  assign w_wr_fin  = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_tmo     = (r_cnt == CW'(C_TIMEOUT - 1));
  assign w_last    = (r_idx == 2'(C_NUM_REGS - 1));
  assign w_idx_nxt = r_idx + 2'd1;

  // Terminal conditions; the sequential block forces FINISH on these
  always_comb begin
    w_fail  = 1'b0;
    w_end   = 1'b0;
    w_fcode = 2'b00;
    unique case (r_state)
      S_WR: begin
        if (!w_wr_fin && w_tmo) begin
          w_fail  = 1'b1;
          w_fcode = 2'b11;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            w_fail  = 1'b1;
            w_fcode = 2'b01;
          end else if (!r_verify && w_last) begin
            w_end = 1'b1;
          end
        end else if (w_tmo) begin
          w_fail  = 1'b1;
          w_fcode = 2'b11;
        end
      end
      S_RD_ADDR: begin
        if (!M_AXI_ARREADY && w_tmo) begin
          w_fail  = 1'b1;
          w_fcode = 2'b11;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            w_fail  = 1'b1;
            w_fcode = 2'b01;
          end
        end else if (w_tmo) begin
          w_fail  = 1'b1;
          w_fcode = 2'b11;
        end
      end
      S_CHECK: begin
        if (r_rdata != r_wdata) begin
          w_fail  = 1'b1;
          w_fcode = 2'b10;
        end else if (w_last) begin
          w_end = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cfg       <= '0;
      r_verify    <= 1'b0;
      r_cnt       <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= 2'b00;
      r_err_index <= 2'b00;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= r_cnt + CW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfg       <= cfg_data;
            r_verify    <= verify;
            r_idx       <= 2'd0;
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
            r_err_index <= 2'b00;
            r_busy      <= 1'b1;
            r_awaddr    <= f_addr(2'd0);
            r_wdata     <= cfg_data[DW-1:0];
            r_wstrb     <= '1;
            r_awvalid   <= 1'b1;
            r_wvalid    <= 1'b1;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_WR;
          end
        end
        S_WR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_wr_fin) begin
            r_bready <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_bready <= 1'b0;
            if (r_verify) begin
              r_arvalid <= 1'b1;
              r_araddr  <= r_awaddr;
              r_cnt     <= '0;
              r_state   <= S_RD_ADDR;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (M_AXI_RVALID) begin
            r_rready <= 1'b0;
            r_rdata  <= M_AXI_RDATA;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: r_state <= S_NEXT;
        S_NEXT: begin
          r_idx     <= w_idx_nxt;
          r_awaddr  <= f_addr(w_idx_nxt);
          r_wdata   <= r_cfg[DW*w_idx_nxt +: DW];
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_cnt     <= '0;
          r_state   <= S_WR;
        end
        S_FINISH: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Timeout drops every VALID even mid-handshake
      if (w_fail || w_end) begin
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_bready  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rready  <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_state   <= S_FINISH;
      end
      if (w_fail) begin
        r_error     <= 1'b1;
        r_err_code  <= w_fcode;
        r_err_index <= r_idx;
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign err_code      = r_err_code;
  assign err_index     = r_err_index;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_threshold_cfg_seq.sv
// Bench for threshold_cfg_seq: memory slave with fault knobs and
// random delays, checked against a per-sequence outcome model.
module tb_threshold_cfg_seq;

  localparam int N   = 4;
  localparam int TMO = 255;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic start = 1'b0;
  logic verify = 1'b0;
  logic [32*N-1:0] cfg_data = '0;
  logic busy, done, error;
  logic [1:0] err_code, err_index;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0] AWPROT, ARPROT;
  logic [3:0] WSTRB;
  logic AWVALID, AWREADY, WVALID, WREADY;
  logic [1:0] BRESP, RRESP;
  logic BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  threshold_cfg_seq dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .verify(verify),
    .cfg_data(cfg_data), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .err_index(err_index),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT),
    .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  bit rnd = 0;
  bit stall_aw = 0;
  bit chk_stab = 0;
  int sl_err_idx = -1;
  int sl_bad_idx = -1;
  int sl_rdly = 0;
  logic [31:0] mem [N];
  logic [63:0] wlog [$];

  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic have_aw, have_w, bpend, rpend;
  logic [31:0] aw_a, w_d;

  function automatic int dly();
    return rnd ? int'($urandom_range(0, 5)) : 0;
  endfunction

  assign AWREADY = !stall_aw && aw_cnt == 0;
  assign WREADY  = w_cnt == 0;
  assign ARREADY = ar_cnt == 0;
  assign BVALID  = bpend && b_cnt == 0;
  assign RVALID  = rpend && r_cnt == 0;

  wire aw_hs = AWVALID && AWREADY;
  wire w_hs  = WVALID && WREADY;
  wire aw_ok = have_aw || aw_hs;
  wire w_ok  = have_w || w_hs;
  wire [31:0] a_eff = have_aw ? aw_a : AWADDR;
  wire [31:0] d_eff = have_w ? w_d : WDATA;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      have_aw <= 0; have_w <= 0; bpend <= 0; rpend <= 0;
      aw_a <= 0; w_d <= 0; BRESP <= 0; RRESP <= 0; RDATA <= 0;
    end else begin
      if (AWVALID && aw_cnt > 0) aw_cnt <= aw_cnt - 1;
      if (WVALID && w_cnt > 0) w_cnt <= w_cnt - 1;
      if (ARVALID && ar_cnt > 0) ar_cnt <= ar_cnt - 1;
      if (bpend && b_cnt > 0) b_cnt <= b_cnt - 1;
      if (rpend && r_cnt > 0) r_cnt <= r_cnt - 1;
      if (aw_hs) begin have_aw <= 1; aw_a <= AWADDR; aw_cnt <= dly(); end
      if (w_hs) begin have_w <= 1; w_d <= WDATA; w_cnt <= dly(); end
      if (aw_ok && w_ok) begin
        mem[a_eff[3:2]] <= d_eff;
        wlog.push_back({a_eff, d_eff});
        have_aw <= 0;
        have_w <= 0;
        bpend <= 1;
        b_cnt <= dly();
        BRESP <= (sl_err_idx >= 0 && a_eff == 32'(4 * sl_err_idx))
                 ? 2'b10 : 2'b00;
      end
      if (BVALID && BREADY) bpend <= 0;
      if (ARVALID && ARREADY) begin
        rpend <= 1;
        r_cnt <= (sl_rdly > 0) ? sl_rdly : dly();
        ar_cnt <= dly();
        RRESP <= 2'b00;
        RDATA <= mem[ARADDR[3:2]] ^
                 ((sl_bad_idx >= 0 && ARADDR == 32'(4 * sl_bad_idx))
                  ? 32'h1 : 32'h0);
      end
      if (RVALID && RREADY) rpend <= 0;
    end
  end

  // VALID and payload must hold until the handshake
  logic p_aw, p_w, p_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  always @(negedge ACLK) begin
    if (chk_stab && ARESETN) begin
      if (p_aw) chk("aw_stable", {AWVALID, AWADDR}, {1'b1, p_awaddr});
      if (p_w)  chk("w_stable", {WVALID, WDATA}, {1'b1, p_wdata});
      if (p_ar) chk("ar_stable", {ARVALID, ARADDR}, {1'b1, p_araddr});
    end
    p_aw <= ARESETN && AWVALID && !AWREADY;
    p_w  <= ARESETN && WVALID && !WREADY;
    p_ar <= ARESETN && ARVALID && !ARREADY;
    p_awaddr <= AWADDR;
    p_wdata  <= WDATA;
    p_araddr <= ARADDR;
  end

  // ---------------- reference model ----------------
  function automatic void ref_model(input logic ver, input int e_i,
      input int b_i, input bit stall, output int code, output int eidx,
      output int nwr);
    code = 0; eidx = 0; nwr = N;
    if (stall) begin code = 3; nwr = 0; return; end
    for (int i = 0; i < N; i++) begin
      if (i == e_i) begin code = 1; eidx = i; nwr = i + 1; return; end
      if (ver && i == b_i) begin code = 2; eidx = i; nwr = i + 1; return; end
    end
  endfunction

  task automatic do_test(input string nm, input logic [32*N-1:0] cfg,
      input logic ver, input int budget, input bit chk_cyc);
    int code, eidx, nwr, cyc, nd, ecyc;
    ref_model(ver, sl_err_idx, sl_bad_idx, stall_aw, code, eidx, nwr);
    ecyc = stall_aw ? TMO + 1 : N * (ver ? 6 : 3);
    wlog.delete();
    @(negedge ACLK);
    cfg_data = cfg; verify = ver; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0; verify = ~ver; cfg_data = ~cfg;
    chk({nm, ":first"}, {busy, AWVALID, WVALID, error}, 4'b1110);
    cyc = 1;
    while (!done && cyc < budget) begin
      @(negedge ACLK);
      cyc++;
    end
    chk({nm, ":done"}, done, 1'b1);
    chk({nm, ":busy"}, busy, 1'b0);
    chk({nm, ":error"}, error, code != 0);
    chk({nm, ":err_code"}, err_code, code[1:0]);
    chk({nm, ":err_index"}, err_index, eidx[1:0]);
    chk({nm, ":valids_low"}, {AWVALID, WVALID, ARVALID}, 3'b000);
    if (chk_cyc) chk({nm, ":cycles"}, cyc, ecyc);
    nd = 1;
    repeat (4) begin
      @(negedge ACLK);
      if (done) nd++;
    end
    chk({nm, ":done_once"}, nd, 1);
    chk({nm, ":nwrites"}, wlog.size(), nwr);
    for (int i = 0; i < nwr && i < wlog.size(); i++)
      chk({nm, ":write"}, wlog[i], {32'(4 * i), cfg[32*i +: 32]});
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, ":ctl"}, {busy, done, error, err_code, err_index, AWPROT,
        AWVALID, WSTRB, WVALID, BREADY, ARPROT, ARVALID, RREADY}, 0);
    chk({nm, ":aw_w"}, {AWADDR, WDATA}, 0);
    chk({nm, ":ar"}, ARADDR, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [32*N-1:0] cfg1 = {32'hbeef0011, 32'hdead0011,
                           32'habcd0001, 32'h0101ffff};
  logic [32*N-1:0] cfg_a, cfg_b;
  int cyc;
  bit saw_done;

  initial begin
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_reset_outs("reset");
    ARESETN = 1'b1;

    do_test("verify_ok", cfg1, 1'b1, 100, 1'b1);
    do_test("noverify_ok", ~cfg1, 1'b0, 100, 1'b1);

    sl_err_idx = 2;
    do_test("slverr", cfg1, 1'b1, 100, 1'b0);
    sl_err_idx = -1;

    sl_bad_idx = 1;
    do_test("badread", cfg1, 1'b1, 100, 1'b0);
    sl_bad_idx = -1;

    stall_aw = 1;
    do_test("timeout", cfg1, 1'b1, 400, 1'b1);
    stall_aw = 0;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;

    rnd = 1; chk_stab = 1;
    for (int k = 0; k < 6; k++)
      do_test("random", {$urandom, $urandom, $urandom, $urandom},
              logic'(k % 2 == 0), 600, 1'b0);
    rnd = 0; chk_stab = 0;

    // second start ignored, then reset during readback
    cfg_a = {$urandom, $urandom, $urandom, $urandom};
    cfg_b = ~cfg_a;
    sl_rdly = 4;
    wlog.delete();
    saw_done = 0;
    @(negedge ACLK);
    cfg_data = cfg_a; verify = 1'b1; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    @(negedge ACLK);
    cfg_data = cfg_b; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    cyc = 0;
    while (!RREADY && cyc < 50) begin
      if (done) saw_done = 1;
      @(negedge ACLK);
      cyc++;
    end
    chk("rst:rd_data_reached", RREADY, 1'b1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    chk_reset_outs("rst");
    @(negedge ACLK);
    if (done) saw_done = 1;
    ARESETN = 1'b1;
    chk("rst:no_done", saw_done, 1'b0);
    chk("rst:nwrites", wlog.size(), 1);
    if (wlog.size() > 0)
      chk("rst:first_write", wlog[0], {32'h0, cfg_a[31:0]});
    sl_rdly = 0;
    do_test("fresh", cfg_b, 1'b1, 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
